// File: rtl/data_sram_if.sv
// Data-side SRAM-like request/response bundle: req/addr_ok handshake, then data_ok pulse.
interface data_sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/data_sram_responder.sv
// Memory end of the data_sram protocol: word RAM with byte-strobe writes, fixed response
// latency and an in-order queue of outstanding requests.
module data_sram_responder #(
  parameter int unsigned AW      = 12,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  data_sram_if.slave bus
);
  localparam int unsigned PtrW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [2:0]  TimerInit = 3'(LATENCY - 1);
  localparam logic [2:0]  QDepthC   = 3'(QDEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(QDEPTH - 1);

  logic [31:0] ram [2**AW];

  logic        ent_wr_q    [QDEPTH];
  logic        ent_wr_d    [QDEPTH];
  logic        ent_err_q   [QDEPTH];
  logic        ent_err_d   [QDEPTH];
  logic [31:0] ent_rdata_q [QDEPTH];
  logic [31:0] ent_rdata_d [QDEPTH];
  logic [2:0]  ent_timer_q [QDEPTH];
  logic [2:0]  ent_timer_d [QDEPTH];

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [2:0]      count_q, count_d;

  logic          addr_ok;
  logic          accept;
  logic          pop;
  logic          illegal;
  logic [3:0]    size_mask;
  logic [3:0]    eff_strb;
  logic [AW-1:0] idx;
  logic [31:0]   ram_word;
  logic          unused_addr;

  assign unused_addr = ^bus.addr[31:AW+2];

  // The same-cycle pop is deliberately not counted: no data_ok -> addr_ok path.
  assign addr_ok = resetn & (count_q < QDepthC);
  assign accept  = bus.req & addr_ok;
  assign pop     = (count_q != 3'd0) && (ent_timer_q[rptr_q] == 3'd0);
  assign idx     = bus.addr[AW+1:2];
  assign ram_word = ram[idx];

  always_comb begin
    illegal   = 1'b0;
    size_mask = 4'b0000;
    unique case (bus.size)
      2'd0: size_mask = 4'b0001 << bus.addr[1:0];
      2'd1: begin
        size_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
        illegal   = bus.addr[0];
      end
      2'd2: begin
        size_mask = 4'b1111;
        illegal   = (bus.addr[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    eff_strb = bus.wstrb & size_mask;
  end

  always_ff @(posedge clk) begin
    if (accept && bus.wr && !illegal) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_strb[b]) ram[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    ent_wr_d    = ent_wr_q;
    ent_err_d   = ent_err_q;
    ent_rdata_d = ent_rdata_q;
    for (int i = 0; i < QDEPTH; i++) begin
      ent_timer_d[i] = (ent_timer_q[i] != 3'd0) ? ent_timer_q[i] - 3'd1 : 3'd0;
    end
    // accept implies count < QDEPTH, so the write slot never aliases a live entry.
    if (accept) begin
      ent_wr_d[wptr_q]    = bus.wr;
      ent_err_d[wptr_q]   = illegal;
      ent_rdata_d[wptr_q] = (!bus.wr && !illegal) ? ram_word : 32'h0;
      ent_timer_d[wptr_q] = TimerInit;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (accept) wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
    if (pop)    rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= 3'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_wr_q[i]    <= 1'b0;
        ent_err_q[i]   <= 1'b0;
        ent_rdata_q[i] <= 32'h0;
        ent_timer_q[i] <= 3'd0;
      end
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ent_wr_q    <= ent_wr_d;
      ent_err_q   <= ent_err_d;
      ent_rdata_q <= ent_rdata_d;
      ent_timer_q <= ent_timer_d;
    end
  end

  assign bus.addr_ok = addr_ok;
  assign bus.data_ok = pop;
  assign bus.err     = pop & ent_err_q[rptr_q];
  assign bus.rdata   = (pop && !ent_wr_q[rptr_q] && !ent_err_q[rptr_q]) ?
                       ent_rdata_q[rptr_q] : 32'h0;
endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with default parameters (AW=12, LATENCY=2, QDEPTH=2).
module tb_data_sram_responder;
  logic clk;
  logic resetn;
  int   errors;
  int   checks;
  int   cyc;
  int   acc_cyc;

  data_sram_if bus ();

  data_sram_responder #(
    .AW     (12),
    .LATENCY(2),
    .QDEPTH (2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n         = 0;
    bus.req   = 1'b1;
    bus.wr    = wr;
    bus.size  = size;
    bus.wstrb = wstrb;
    bus.addr  = addr;
    bus.wdata = wdata;
    while (!bus.addr_ok && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout addr=%h addr_ok=%b required 1", addr, bus.addr_ok);
    end
    tick();
    acc_cyc = cyc;
    bus.req = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!bus.data_ok && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.data_ok !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout data_ok=%b required 1", bus.data_ok);
    end
    rd  = bus.rdata;
    er  = bus.err;
    lat = cyc - acc_cyc + 1;
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.addr_ok, bus.data_ok, bus.err, bus.rdata} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs addr_ok=%b data_ok=%b err=%b rdata=%h required all 0",
               bus.addr_ok, bus.data_ok, bus.err, bus.rdata);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (bus.addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL reset_release addr_ok=%b required 1", bus.addr_ok);
    end
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd;
    logic        er;
    int          lat;
    issue(1'b1, 2'd2, 4'b1111, 32'h0000_1004, 32'hDEAD_BEEF);
    wait_resp(rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL store_resp rdata=%h err=%b lat=%0d required 0 0 2", rd, er, lat);
    end
    issue(1'b0, 2'd2, 4'b0000, 32'h0000_1004, 32'h0);
    wait_resp(rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL word_load rdata=%h err=%b required deadbeef 0", rd, er);
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL load_latency got=%0d required 2", lat);
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd;
    logic        er;
    int          lat;
    issue(1'b1, 2'd0, 4'b0100, 32'h0000_1006, 32'h00AB_0000);
    wait_resp(rd, er, lat);
    issue(1'b0, 2'd2, 4'b0000, 32'h0000_1004, 32'h0);
    wait_resp(rd, er, lat);
    checks++;
    if (rd !== 32'hDEAB_BEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_merge rdata=%h err=%b required deabbeef 0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        er;
    int          lat;
    issue(1'b1, 2'd2, 4'b1111, 32'h0000_1000, 32'h1111_1111);
    wait_resp(rd, er, lat);
    issue(1'b1, 2'd2, 4'b1111, 32'h0000_1008, 32'h2222_2222);
    wait_resp(rd, er, lat);
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.wstrb = 4'b0000;
    bus.addr = 32'h0000_1000;
    checks++;
    if (bus.addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ok addr_ok=%b required 1", bus.addr_ok);
    end
    tick();
    bus.addr = 32'h0000_1004;
    checks++;
    if (bus.addr_ok !== 1'b1 || bus.data_ok !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second addr_ok=%b data_ok=%b required 1 0", bus.addr_ok, bus.data_ok);
    end
    tick();
    bus.addr = 32'h0000_1008;
    checks++;
    if (bus.addr_ok !== 1'b0 || bus.data_ok !== 1'b1 || bus.rdata !== 32'h1111_1111) begin
      errors++;
      $display("FAIL b2b_full addr_ok=%b data_ok=%b rdata=%h required 0 1 11111111",
               bus.addr_ok, bus.data_ok, bus.rdata);
    end
    tick();
    checks++;
    if (bus.addr_ok !== 1'b1 || bus.data_ok !== 1'b1 || bus.rdata !== 32'hDEAB_BEEF) begin
      errors++;
      $display("FAIL b2b_third addr_ok=%b data_ok=%b rdata=%h required 1 1 deabbeef",
               bus.addr_ok, bus.data_ok, bus.rdata);
    end
    tick();
    bus.req = 1'b0;
    checks++;
    if (bus.data_ok !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap data_ok=%b required 0", bus.data_ok);
    end
    tick();
    checks++;
    if (bus.data_ok !== 1'b1 || bus.rdata !== 32'h2222_2222 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last data_ok=%b rdata=%h err=%b required 1 22222222 0",
               bus.data_ok, bus.rdata, bus.err);
    end
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    issue(1'b1, 2'd2, 4'b1111, 32'h0000_1002, 32'hFFFF_FFFF);
    wait_resp(rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_store rdata=%h err=%b required 0 1", rd, er);
    end
    issue(1'b0, 2'd2, 4'b0000, 32'h0000_1000, 32'h0);
    wait_resp(rd, er, lat);
    checks++;
    if (rd !== 32'h1111_1111 || er !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_no_write rdata=%h err=%b required 11111111 0", rd, er);
    end
    issue(1'b0, 2'd3, 4'b0000, 32'h0000_1000, 32'h0);
    wait_resp(rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL size3_load rdata=%h err=%b required 0 1", rd, er);
    end
    issue(1'b0, 2'd1, 4'b0000, 32'h0000_1001, 32'h0);
    wait_resp(rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL half_misaligned rdata=%h err=%b required 0 1", rd, er);
    end
    // Strobes outside the half mask must not reach the RAM.
    issue(1'b1, 2'd1, 4'b1111, 32'h0000_1000, 32'hAAAA_5555);
    wait_resp(rd, er, lat);
    issue(1'b0, 2'd2, 4'b0000, 32'h0000_1000, 32'h0);
    wait_resp(rd, er, lat);
    checks++;
    if (rd !== 32'h1111_5555 || er !== 1'b0) begin
      errors++;
      $display("FAIL half_mask rdata=%h err=%b required 11115555 0", rd, er);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.wstrb = 4'b0000;
    bus.addr = 32'h0000_1004;
    tick();
    bus.addr = 32'h0000_1008;
    tick();
    bus.req = 1'b0;
    resetn  = 1'b0;
    #1;
    checks++;
    if ({bus.addr_ok, bus.data_ok, bus.err, bus.rdata} !== 35'h0) begin
      errors++;
      $display("FAIL midop_reset addr_ok=%b data_ok=%b err=%b rdata=%h required all 0",
               bus.addr_ok, bus.data_ok, bus.err, bus.rdata);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    checks++;
    if (bus.addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL midop_release addr_ok=%b required 1", bus.addr_ok);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.data_ok) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL dropped_resp data_ok_count=%0d required 0", seen);
    end
    issue(1'b0, 2'd2, 4'b0000, 32'h0000_1004, 32'h0);
    wait_resp(rd, er, lat);
    checks++;
    if (rd !== 32'hDEAB_BEEF || er !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL store_survives rdata=%h err=%b lat=%0d required deabbeef 0 2", rd, er, lat);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd;
    logic        er;
    int          lat;
    issue(1'b1, 2'd2, 4'b1111, 32'h0000_4004, 32'h1234_5678);
    wait_resp(rd, er, lat);
    issue(1'b0, 2'd2, 4'b0000, 32'h0000_0004, 32'h0);
    wait_resp(rd, er, lat);
    checks++;
    if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      errors++;
      $display("FAIL alias rdata=%h err=%b required 12345678 0", rd, er);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    acc_cyc   = 0;
    resetn    = 1'b0;
    bus.req   = 1'b0;
    bus.wr    = 1'b0;
    bus.size  = 2'd0;
    bus.wstrb = 4'b0000;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    tick();
    tick();
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_back_to_back();
    test_errors();
    test_reset_midop();
    test_alias();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
